// File: rtl/pe_psum_drain.sv
// ---------------------------------------------------------------------------
// pe_psum_drain
//
// Purpose:
//   Read-out engine for a PE's double-buffered psum register file. After a
//   bank swap, the PE-array controller pulses `start`. This block then walks
//   the bank the MAC is not using from address 0 upward. It captures the
//   bank's registered read data one cycle after each address and streams the
//   entries over a valid/ready interface toward the spatial-unrolling adder.
//
// Ports:
//   clk                 - single clock, rising edge
//   reset               - synchronous, active-low reset
//   start               - one-cycle drain request
//   psum_en             - MAC bank select, latched at accepted start
//                         (1 -> drain psum_out2, 0 -> drain psum_out1)
//   drain_len           - entry count, latched and clamped to PSUM_DEPTH
//   addr_from_su_adder  - psum RF read address
//   psum_out1/psum_out2 - RF bank outputs, valid one cycle after the address
//   out_data/out_valid/out_ready/out_last - streamed psum beats
//   busy                - drain in progress (state not IDLE)
//   done                - one-cycle pulse after the final handshake
//   err                 - sticky: start arrived while busy
// ---------------------------------------------------------------------------
module pe_psum_drain #(
  parameter int OUT_BITWIDTH       = 16,
  parameter int PSUM_ADDR_BITWIDTH = 2,
  parameter int PSUM_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          psum_en,
  input  logic [PSUM_ADDR_BITWIDTH:0]   drain_len,
  output logic [PSUM_ADDR_BITWIDTH-1:0] addr_from_su_adder,
  input  logic [OUT_BITWIDTH-1:0]       psum_out1,
  input  logic [OUT_BITWIDTH-1:0]       psum_out2,
  output logic [OUT_BITWIDTH-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  localparam int AW = PSUM_ADDR_BITWIDTH;
  localparam logic [AW:0] DEPTH_L = PSUM_DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            bank_q, bank_d;
  logic [AW:0]     len_q, len_d;
  logic [AW:0]     issueCnt_q, issueCnt_d;
  logic [AW:0]     beatCnt_q, beatCnt_d;
  logic [AW-1:0]   lastAddr_q, lastAddr_d;
  logic            pending_q, pending_d;
  logic            err_q, err_d;
  logic [1:0]      count_q, count_d;

  logic [OUT_BITWIDTH-1:0] fifoMem_q [2];
  logic                    wrPtr_q;
  logic                    rdPtr_q;

  logic            pop;
  logic            push;
  logic            issue;
  logic [AW:0]     clampedLen;
  logic [OUT_BITWIDTH-1:0] captureData;

  // The clamp keeps the address walk inside the RF, so the address never wraps.
  assign clampedLen  = (drain_len > DEPTH_L) ? DEPTH_L : drain_len;
  assign captureData = bank_q ? psum_out2 : psum_out1;

  assign pop  = out_valid & out_ready;
  assign push = pending_q;

  // Credit check: buffered entries plus the read in flight must still fit in the
  // two-entry FIFO, counting a beat leaving this cycle as freed space. Counting
  // the pop lets the stream sustain one beat per cycle with out_ready held high.
  assign issue = (state_q == READ) &&
                 (({1'b0, count_q} + {2'b00, pending_q}) < (3'd2 + {2'b00, pop}));

  // The address is shown combinationally while issuing. Otherwise the last
  // issued address is held.
  assign addr_from_su_adder = issue ? issueCnt_q[AW-1:0] : lastAddr_q;
  assign out_valid          = (count_q != 2'd0);
  assign out_data           = fifoMem_q[rdPtr_q];
  assign out_last           = out_valid && (beatCnt_q == (len_q - 1'b1));
  assign busy               = (state_q != IDLE);
  assign done               = (state_q == DONE);
  assign err                = err_q;

  // Next-state logic for the drain FSM and its counters.
  // Every register holds its value unless a case below updates it.
  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    len_d      = len_q;
    issueCnt_d = issueCnt_q;
    beatCnt_d  = beatCnt_q;
    lastAddr_d = lastAddr_q;
    pending_d  = issue;
    err_d      = err_q;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};

    if (issue) begin
      issueCnt_d = issueCnt_q + 1'b1;
      lastAddr_d = issueCnt_q[AW-1:0];
    end
    if (pop) begin
      beatCnt_d = beatCnt_q + 1'b1;
    end
    if (start && (state_q != IDLE)) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          bank_d     = psum_en;
          len_d      = clampedLen;
          issueCnt_d = '0;
          beatCnt_d  = '0;
          state_d    = (clampedLen == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issue && ((issueCnt_q + 1'b1) == len_q)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Leave FLUSH in the cycle that drains the final buffered beat, so done
        // follows the last handshake directly.
        if (!pending_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers.
  // Reset clears everything, which aborts any drain in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      bank_q     <= 1'b0;
      len_q      <= '0;
      issueCnt_q <= '0;
      beatCnt_q  <= '0;
      lastAddr_q <= '0;
      pending_q  <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      len_q      <= len_d;
      issueCnt_q <= issueCnt_d;
      beatCnt_q  <= beatCnt_d;
      lastAddr_q <= lastAddr_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  // Two-entry capture FIFO. The read data is written the cycle after its
  // address was issued. Unsent beats are discarded on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        fifoMem_q[i] <= '0;
      end
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
    end else begin
      if (push) begin
        fifoMem_q[wrPtr_q] <= captureData;
        wrPtr_q            <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
    end
  end

endmodule

// File: tb/tb_pe_psum_drain.sv
// ---------------------------------------------------------------------------
// tb_pe_psum_drain
//
// Purpose:
//   Directed bench for pe_psum_drain. A registered two-bank psum RF model
//   drives psum_out1/psum_out2. Each scenario compares the DUT's streamed
//   beats and control outputs against hand-written expected values.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_pe_psum_drain;

  logic        clk;
  logic        reset;
  logic        start;
  logic        psum_en;
  logic [2:0]  drain_len;
  logic [1:0]  addr_from_su_adder;
  logic [15:0] psum_out1;
  logic [15:0] psum_out2;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  int total;
  int bad;
  bit errSticky;

  logic [15:0] bank1 [4];
  logic [15:0] bank2 [4];
  int          expData [4];

  pe_psum_drain #(
    .OUT_BITWIDTH(16),
    .PSUM_ADDR_BITWIDTH(2),
    .PSUM_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .psum_en(psum_en),
    .drain_len(drain_len),
    .addr_from_su_adder(addr_from_su_adder),
    .psum_out1(psum_out1),
    .psum_out2(psum_out2),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
    .done(done),
    .err(err)
  );

  // Free-running clock with a 10-time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered psum RF model. Data appears one cycle after its address.
  initial begin
    psum_out1 = '0;
    psum_out2 = '0;
  end
  always @(posedge clk) begin
    psum_out1 <= bank1[addr_from_su_adder];
    psum_out2 <= bank2[addr_from_su_adder];
  end

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives all handshake and control inputs for the current cycle.
  task automatic applyStimulus(input logic st, input logic en, input logic [2:0] ln, input logic rdy);
    start     = st;
    psum_en   = en;
    drain_len = ln;
    out_ready = rdy;
  endtask

  // Runs one drain and checks its beats with a scoreboard.
  // readyMode 0 holds out_ready high and also checks cycle-exact timing.
  // readyMode 1 asserts out_ready only every third cycle.
  // toggleEn scrambles psum_en and drain_len after start.
  // overlap adds a second start pulse in cycle 2.
  task automatic runDrain(input string tag, input logic enV, input logic [2:0] lenV,
                          input int nExp, input int readyMode, input bit toggleEn,
                          input bit overlap);
    int  doneExp;
    int  idx;
    bit  doneSeen;
    logic rdy;
    doneExp  = (nExp == 0) ? 1 : nExp + 3;
    idx      = 0;
    doneSeen = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, enV, lenV, (readyMode == 0));
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      rdy = (readyMode == 0) ? 1'b1 : ((cyc % 3) == 0);
      applyStimulus(overlap && (cyc == 2),
                    toggleEn ? ((cyc % 2) == 1) : enV,
                    toggleEn ? 3'd1 : lenV, rdy);
      #1;
      checkOutput($sformatf("%s err c%0d", tag, cyc), err, errSticky | (overlap && cyc >= 3));
      if (readyMode == 0) begin
        checkOutput($sformatf("%s busy c%0d", tag, cyc), busy, (cyc <= doneExp));
        checkOutput($sformatf("%s done c%0d", tag, cyc), done, (cyc == doneExp));
        checkOutput($sformatf("%s valid c%0d", tag, cyc), out_valid,
                    (nExp > 0) && (cyc >= 3) && (cyc <= nExp + 2));
        if ((nExp > 0) && (cyc <= nExp + 2)) begin
          checkOutput($sformatf("%s addr c%0d", tag, cyc), addr_from_su_adder,
                      (cyc <= nExp) ? cyc - 1 : nExp - 1);
        end
      end
      if (out_valid) begin
        if (idx < nExp) begin
          checkOutput($sformatf("%s data b%0d", tag, idx), out_data, expData[idx]);
          checkOutput($sformatf("%s last b%0d", tag, idx), out_last, (idx == nExp - 1));
        end else begin
          checkOutput($sformatf("%s extraBeat", tag), idx, nExp);
        end
        if (out_ready) idx++;
      end
      if (doneSeen) begin
        checkOutput($sformatf("%s busyAfterDone", tag), busy, 0);
        break;
      end
      if (done) doneSeen = 1'b1;
    end
    checkOutput($sformatf("%s beats", tag), idx, nExp);
    checkOutput($sformatf("%s doneSeen", tag), doneSeen, 1);
    if (overlap) errSticky = 1'b1;
  endtask

  // Scenario sequence: reset, full rate, backpressure, bank select with clamp,
  // zero length, overlapping start, and reset in the middle of a drain.
  initial begin
    total     = 0;
    bad       = 0;
    errSticky = 1'b0;
    reset     = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b1);
    bank1[0] = 16'd5;  bank1[1] = 16'd6;  bank1[2] = 16'd7;  bank1[3] = 16'd8;
    bank2[0] = 16'd10; bank2[1] = 16'd20; bank2[2] = 16'd30; bank2[3] = 16'd40;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst addr", addr_from_su_adder, 0);
    checkOutput("rst valid", out_valid, 0);
    checkOutput("rst last", out_last, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst done", done, 0);
    checkOutput("rst err", err, 0);
    checkOutput("rst data", out_data, 0);
    reset = 1'b1;
    @(negedge clk);

    expData[0] = 10; expData[1] = 20; expData[2] = 30; expData[3] = 40;
    runDrain("full", 1'b1, 3'd4, 4, 0, 1'b0, 1'b0);
    runDrain("bp", 1'b1, 3'd4, 4, 1, 1'b0, 1'b0);

    expData[0] = 5; expData[1] = 6; expData[2] = 7; expData[3] = 8;
    runDrain("clamp", 1'b0, 3'd7, 4, 0, 1'b1, 1'b0);

    runDrain("zero", 1'b1, 3'd0, 0, 0, 1'b0, 1'b0);

    expData[0] = 10; expData[1] = 20; expData[2] = 30; expData[3] = 40;
    runDrain("ovl", 1'b1, 3'd4, 4, 0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 3'd4, 1'b1);
      #1;
      checkOutput($sformatf("ovl idle busy %0d", i), busy, 0);
      checkOutput($sformatf("ovl idle valid %0d", i), out_valid, 0);
      checkOutput($sformatf("ovl idle err %0d", i), err, 1);
    end

    // Reset in the middle of a drain: beats 0 and 1 go out in cycles 3 and 4,
    // and reset is sampled at the edge that ends cycle 5.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 3'd4, 1'b1);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 3'd4, 1'b1);
      reset = (cyc == 5) ? 1'b0 : 1'b1;
      #1;
      if (cyc == 3) checkOutput("rmid b0", out_data, 10);
      if (cyc == 4) checkOutput("rmid b1", out_data, 20);
      if (cyc == 6) begin
        checkOutput("rmid addr", addr_from_su_adder, 0);
        checkOutput("rmid valid", out_valid, 0);
        checkOutput("rmid last", out_last, 0);
        checkOutput("rmid busy", busy, 0);
        checkOutput("rmid done", done, 0);
        checkOutput("rmid err", err, 0);
        checkOutput("rmid data", out_data, 0);
      end
    end
    errSticky = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("rmid nodone %0d", i), done, 0);
      checkOutput($sformatf("rmid idle %0d", i), busy, 0);
    end

    bank2[0] = 16'd11; bank2[1] = 16'd22; bank2[2] = 16'd33; bank2[3] = 16'd44;
    expData[0] = 11; expData[1] = 22; expData[2] = 33; expData[3] = 44;
    runDrain("after", 1'b1, 3'd4, 4, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_psum_drain.md
# pe_psum_drain

Read-out engine for a PE's double-buffered psum register file. Once a psum bank swap has occurred, it walks the bank the MAC is not using: it drives `addr_from_su_adder`, captures the bank's registered `psum_out1`/`psum_out2` data, and streams the entries over a valid/ready interface toward the spatial-unrolling adder tree. It sits between one PE and the SU adder, and a PE-array controller starts it with a single pulse per bank swap.

## Interface
- `OUT_BITWIDTH`, 16, psum data width
- `PSUM_ADDR_BITWIDTH`, 2, psum RF address width
- `PSUM_DEPTH`, 4, psum RF entries (= 2^PSUM_ADDR_BITWIDTH)

- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle pulse requesting a drain
- `psum_en`  in  1  PE's current MAC bank select, latched at accepted start (1 → drain `psum_out2`, 0 → drain `psum_out1`)
- `drain_len`  in  PSUM_ADDR_BITWIDTH+1  number of entries to drain, latched at accepted start
- `addr_from_su_adder`  out  PSUM_ADDR_BITWIDTH  psum RF read address
- `psum_out1`, `psum_out2`  in  OUT_BITWIDTH  PSUM_RF bank outputs, valid one cycle after the address
- `out_data`  out  OUT_BITWIDTH  streamed psum
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  consumer accepts
- `out_last`  out  1  marks the final beat (qualified by `out_valid`)
- `busy`  out  1  drain in progress
- `done`  out  1  one-cycle pulse after the final handshake
- `err`  out  1  sticky flag: start arrived while busy

## Operation
- FSM states:
  - IDLE: waits for `start`. An accepted start latches the bank and `len = min(drain_len, PSUM_DEPTH)`, clears the issue and beat counters, and moves to READ. If `len` = 0, the FSM goes straight to DONE with no beats.
  - READ: issues one read address per cycle while credit allows. After `len` issues it moves to FLUSH.
  - FLUSH: waits until in-flight reads = 0 and the FIFO is empty, then moves to DONE.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- Read addresses start at 0 and increment by 1; no wrap is possible because `len` ≤ `PSUM_DEPTH`.
- Read data: `psum_out1` or `psum_out2`, selected by the latched bank, is captured one cycle after its address into a 2-entry FIFO.
- Credit rule: a read issues only if `occupancy + inflight − pop < 2`, where `pop = out_valid & out_ready` in the same cycle. This sustains one beat per cycle when `out_ready` is held high.
- Output stream:
  - `out_valid` = FIFO non-empty; `out_data` = FIFO head.
  - `out_data` holds stable while `out_valid` is high and `out_ready` is low.
- `out_last` is asserted on the beat whose index = `len` − 1.
- `busy` = (state ≠ IDLE).
- A `start` pulse while busy is ignored, sets `err` (which stays set until reset), and does not disturb the current drain.
- A `drain_len` value greater than `PSUM_DEPTH` is clamped to `PSUM_DEPTH`.
- Changes on `psum_en` or `drain_len` after an accepted start have no effect on the current drain.

## Timing
- Reset values (`reset` = 0 at a clock edge):
  - state IDLE; FIFO, counters and in-flight tracking cleared.
  - `addr_from_su_adder` = 0, `out_valid` = 0, `out_last` = 0, `busy` = 0, `done` = 0, `err` = 0, `out_data` = 0.
- Reset mid-drain aborts the drain immediately. No `done` is produced, and any unsent beats are discarded.
- Start sampled at edge E0 (cycle 0):
  - `busy` = 1 in cycle 1, with address 0 driven in cycle 1.
  - Data is captured at E2, and `out_valid` = 1 in cycle 3.
  - Start-to-first-beat latency = 3 cycles.
- With `out_ready` held at 1 and `len` = N:
  - beats appear in cycles 3 … N+2.
  - `done` = 1 in cycle N+3; IDLE (`busy` = 0) in cycle N+4.
- With `len` = 0: `busy` = 1 in cycle 1 (DONE), `done` = 1 in cycle 1, IDLE in cycle 2.
- `addr_from_su_adder` holds its last issued value when no read is issuing.
- `start` in the same cycle as the `done` pulse is treated as start-while-busy (ignored, `err` set).
- `start` in the cycle after DONE (state IDLE) is accepted normally.

## Test plan
- Full-rate drain: bank 2 preloaded with 10, 20, 30, 40; `psum_en` = 1, `drain_len` = 4, `out_ready` = 1 → beats 10, 20, 30, 40 in cycles 3–6, `out_last` only on 40, `done` in cycle 7, addresses 0–3 in cycles 1–4.
- Backpressure: same data, `out_ready` toggling 1,0,0,1,… → no beat lost or duplicated, `out_data` stable while stalled, at most 2 in flight plus buffered, order preserved.
- Bank select and clamp: `psum_en` = 0, bank 1 = 5, 6, 7, 8, `drain_len` = 7 → exactly 4 beats 5, 6, 7, 8; `psum_en` toggled mid-drain has no effect.
- Zero length: `drain_len` = 0 → no `out_valid`, `done` in cycle 1, `busy` deasserted in cycle 2.
- Overlap: second `start` in cycle 2 of a 4-entry drain → `err` goes to 1 and stays until reset, the first drain completes unchanged, and no second drain follows.
- Reset mid-drain: `reset` = 0 for one edge after beat 2 → all outputs return to reset values the next cycle, with no `done`; a new `start` then drains correctly from address 0.
